byte_ingress: RTL and testbench
===============================

# byte_ingress

Receives a stream of bytes from an 8-bit link and reassembles them into 32-bit words, least-significant byte first. It is the receive-side counterpart of the byte egress serializer, with a matching port naming so the two connect back-to-back for loopback. There is no backpressure in either direction. An optional inter-byte timeout discards stale partial words so the receiver resynchronizes after a truncated transfer.

## Interface
- TIMEOUT_CYCLES, 16: consecutive idle cycles with a partial word held before that word is discarded. Legal range is 2..255. Used only when the timeout feature is compiled in.

- ClkIngress  input  1  single clock; all logic is on its rising edge
- ARst  input  1  asynchronous, active-high reset
- Data  input  8  incoming byte
- DataValid  input  1  Data is valid this cycle; one byte is accepted per cycle when high
- Flush  input  1  synchronous clear of any partial word
- WriteData  output  32  last completed word; held until the next word completes
- WriteDataValid  output  1  one-cycle pulse marking a new WriteData
- Busy  output  1  high while 1–3 bytes of a word are held
- TimeoutErr  output  1  one-cycle pulse when a partial word is discarded by timeout

## Operation
- Internal state:
  - 2-bit byteNum: index of the next byte slot.
  - 24-bit partial register: bytes 0–2.
  - Idle counter: 8 bits, present only with the timeout feature.
- Byte placement:
  - byteNum 0 → bits [7:0].
  - byteNum 1 → [15:8].
  - byteNum 2 → [23:16].
  - byteNum 3 → [31:24], completing the word.
- Accept cycle (DataValid=1, Flush=0):
  - Store the byte and increment byteNum, wrapping 3→0.
  - On byteNum=3: at that edge, WriteData ← {Data, partial[23:0]} and WriteDataValid ← 1.
- WriteDataValid is 0 in every other cycle. WriteData never changes except on word completion or reset.
- Busy is registered; it equals (byteNum≠0) after each edge.
- Flush=1:
  - byteNum ← 0 and the idle counter ← 0.
  - A byte presented in the same cycle is discarded.
  - Flush has priority over DataValid and over the timeout.
  - A word completed in an earlier cycle is unaffected.
- Back-to-back words with DataValid held high continuously are supported at full rate: one word every 4 cycles with no gap.
- Partial contents are don't-care while byteNum=0. Data is sampled only when DataValid=1.

## Timing
- Reset values (ARst high): byteNum=0, idle counter=0, WriteData=32'h0, WriteDataValid=0, Busy=0, TimeoutErr=0.
- Reset is asynchronous assert. A reset mid-word discards the partial word with no TimeoutErr.
- Latency: WriteDataValid is high in the cycle immediately after the edge that samples the 4th byte. It is a 1-cycle pulse.
- Gaps between bytes (DataValid low) of any length are tolerated unless the timeout feature discards the word.
- Idle counter behaviour (timeout feature only):
  - Increments each cycle with Busy=1, DataValid=0 and Flush=0.
  - Clears on any accepted byte, on Flush, and whenever Busy=0.
- Timeout event, on the edge where the counter would reach TIMEOUT_CYCLES:
  - byteNum ← 0, counter ← 0, TimeoutErr ← 1 for one cycle.
  - Busy falls at the same edge.
- A byte arriving with DataValid=1 is never a timeout: it clears the counter and is accepted normally.
- Flush and timeout in the same cycle: Flush wins and TimeoutErr stays 0.

## Configuration
- BYTE_INGRESS_TIMEOUT_EN defined:
  - The idle counter and timeout logic are built.
  - TimeoutErr behaves as specified above.
- BYTE_INGRESS_TIMEOUT_EN undefined:
  - No counter is built and TIMEOUT_CYCLES is ignored.
  - TimeoutErr is tied to 0.
  - A partial word is held indefinitely, until completed, flushed or reset.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles → WriteData=0x44332211. WriteDataValid is high for exactly the one cycle after the 0x44 cycle. Busy is 1 for the three cycles after the first three bytes.
- Loopback from the byte egress block:
  - Write 0xDEADBEEF, then 0x01234567 four cycles later.
  - Expect two WriteDataValid pulses, 4 cycles apart, with those exact values.
- Gapped input with 3 idle cycles between bytes 0xA0, 0xA1, 0xA2, 0xA3 (timeout 16) → WriteData=0xA3A2A1A0 and TimeoutErr stays 0.
- With the macro defined:
  - Send bytes 0x55, 0x66, then stay idle. TimeoutErr pulses on the 16th idle edge, Busy drops and WriteData is unchanged.
  - Then send 0x01, 0x02, 0x03, 0x04 → 0x04030201.
  - Repeat with the macro undefined → no TimeoutErr; the next 2 bytes complete a word containing 0x55, 0x66.
- Flush after 2 bytes, coinciding with a third byte 0x77. Then send 0x10, 0x20, 0x30, 0x40 → WriteData=0x40302010, with no trace of 0x77.
- Assert ARst after 3 bytes → all outputs return to their reset values immediately. Then send 0xC1, 0xC2, 0xC3, 0xC4 → WriteData=0xC4C3C2C1.

Source files
------------

// File: rtl/byte_ingress.sv
// Byte-to-word reassembler, LSB first; optional stale-word timeout built when BYTE_INGRESS_TIMEOUT_EN is defined.
// Latency: WriteDataValid pulses the cycle after the edge that samples the 4th byte.
// Backpressure: none; one byte is accepted in every cycle that DataValid is high.
module byte_ingress #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ClkIngress,
    input  logic        ARst,
    input  logic [7:0]  Data,
    input  logic        DataValid,
    input  logic        Flush,
    output logic [31:0] WriteData,
    output logic        WriteDataValid,
    output logic        Busy,
    output logic        TimeoutErr
);

    logic [1:0]  byteNum;
    logic [23:0] partial;

`ifdef BYTE_INGRESS_TIMEOUT_EN
    localparam logic [7:0] IdleLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] idleCnt;
    logic       timeoutErrQ;

    assign TimeoutErr = timeoutErrQ;
`else
    logic [7:0] unusedTimeoutCfg;

    assign unusedTimeoutCfg = 8'(TIMEOUT_CYCLES);
    assign TimeoutErr       = 1'b0;
`endif

    always_ff @(posedge ClkIngress or posedge ARst) begin
        if (ARst) begin
            byteNum        <= 2'd0;
            partial        <= 24'h0;
            WriteData      <= 32'h0;
            WriteDataValid <= 1'b0;
            Busy           <= 1'b0;
`ifdef BYTE_INGRESS_TIMEOUT_EN
            idleCnt        <= 8'd0;
            timeoutErrQ    <= 1'b0;
`endif
        end else begin
            WriteDataValid <= 1'b0;
`ifdef BYTE_INGRESS_TIMEOUT_EN
            timeoutErrQ    <= 1'b0;
`endif
            if (Flush) begin
                // A byte presented alongside Flush is dropped on purpose.
                byteNum <= 2'd0;
                Busy    <= 1'b0;
`ifdef BYTE_INGRESS_TIMEOUT_EN
                idleCnt <= 8'd0;
`endif
            end else if (DataValid) begin
                case (byteNum)
                    2'd0:    partial[7:0]   <= Data;
                    2'd1:    partial[15:8]  <= Data;
                    2'd2:    partial[23:16] <= Data;
                    default: begin
                        WriteData      <= {Data, partial};
                        WriteDataValid <= 1'b1;
                    end
                endcase
                byteNum <= byteNum + 2'd1;
                Busy    <= (byteNum != 2'd3);
`ifdef BYTE_INGRESS_TIMEOUT_EN
                idleCnt <= 8'd0;
`endif
            end
`ifdef BYTE_INGRESS_TIMEOUT_EN
            else if (byteNum != 2'd0) begin
                // Fire on the edge the count would reach TIMEOUT_CYCLES.
                if (idleCnt == IdleLast) begin
                    byteNum     <= 2'd0;
                    Busy        <= 1'b0;
                    idleCnt     <= 8'd0;
                    timeoutErrQ <= 1'b1;
                end else begin
                    idleCnt <= idleCnt + 8'd1;
                end
            end else begin
                idleCnt <= 8'd0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_byte_ingress.sv
// Scoreboard bench for byte_ingress: expected words are queued as bytes are driven and popped on WriteDataValid.
module tb_byte_ingress;

    logic        ClkIngress = 1'b0;
    logic        ARst;
    logic [7:0]  Data;
    logic        DataValid;
    logic        Flush;
    logic [31:0] WriteData;
    logic        WriteDataValid;
    logic        Busy;
    logic        TimeoutErr;

    int checks = 0;
    int errors = 0;
    int toCount = 0;
    logic [31:0] expQ[$];

    byte_ingress #(.TIMEOUT_CYCLES(16)) dut (
        .ClkIngress     (ClkIngress),
        .ARst           (ARst),
        .Data           (Data),
        .DataValid      (DataValid),
        .Flush          (Flush),
        .WriteData      (WriteData),
        .WriteDataValid (WriteDataValid),
        .Busy           (Busy),
        .TimeoutErr     (TimeoutErr)
    );

    always #5 ClkIngress = ~ClkIngress;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every completed word must match the oldest queued expectation.
    always @(negedge ClkIngress) begin
        if (!ARst) begin
            if (WriteDataValid) begin
                if (expQ.size() == 0) check("unexpectedWord", WriteData, 32'hx);
                else check("sbWord", WriteData, expQ.pop_front());
            end
            if (TimeoutErr) toCount++;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        Data      = b;
        DataValid = 1'b1;
        @(posedge ClkIngress);
        #1;
        DataValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ClkIngress);
            #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] w);
        expQ.push_back(w);
        for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARst = 1'b1; Data = 8'h0; DataValid = 1'b0; Flush = 1'b0;
        @(posedge ClkIngress);
        @(posedge ClkIngress);
        #1;
        check("rstWriteData", WriteData, 32'h0);
        check("rstWdv", 32'(WriteDataValid), 32'd0);
        check("rstBusy", 32'(Busy), 32'd0);
        check("rstTimeout", 32'(TimeoutErr), 32'd0);
        ARst = 1'b0;
        idle(1);

        // Basic word with per-byte Busy and exact pulse timing.
        expQ.push_back(32'h44332211);
        sendByte(8'h11); check("busyB1", 32'(Busy), 32'd1);
        sendByte(8'h22); check("busyB2", 32'(Busy), 32'd1);
        sendByte(8'h33); check("busyB3", 32'(Busy), 32'd1);
        check("wdvEarly", 32'(WriteDataValid), 32'd0);
        sendByte(8'h44);
        check("wdvPulse", 32'(WriteDataValid), 32'd1);
        check("word1", WriteData, 32'h44332211);
        check("busyAfterWord", 32'(Busy), 32'd0);
        idle(1);
        check("wdvOneCycle", 32'(WriteDataValid), 32'd0);
        idle(3);
        check("wordHeld", WriteData, 32'h44332211);

        // Loopback-style back-to-back words, 4 cycles apart.
        sendWord(32'hDEADBEEF);
        check("lbPulse1", 32'(WriteDataValid), 32'd1);
        check("lbWord1", WriteData, 32'hDEADBEEF);
        expQ.push_back(32'h01234567);
        sendByte(8'h67); check("lbGap1", 32'(WriteDataValid), 32'd0);
        sendByte(8'h45); check("lbGap2", 32'(WriteDataValid), 32'd0);
        sendByte(8'h23); check("lbGap3", 32'(WriteDataValid), 32'd0);
        sendByte(8'h01);
        check("lbPulse2", 32'(WriteDataValid), 32'd1);
        check("lbWord2", WriteData, 32'h01234567);
        idle(2);

        // Gapped bytes, 3 idle cycles apart.
        expQ.push_back(32'hA3A2A1A0);
        for (int i = 0; i < 4; i++) begin
            sendByte(8'hA0 + 8'(i));
            if (i < 3) idle(3);
        end
        check("gapWord", WriteData, 32'hA3A2A1A0);
        check("gapNoTimeout", 32'(toCount), 32'd0);
        idle(2);

`ifdef BYTE_INGRESS_TIMEOUT_EN
        sendByte(8'h55);
        sendByte(8'h66);
        idle(15);
        check("toNotYet", 32'(TimeoutErr), 32'd0);
        check("toBusyHeld", 32'(Busy), 32'd1);
        idle(1);
        check("toPulse", 32'(TimeoutErr), 32'd1);
        check("toBusyDrop", 32'(Busy), 32'd0);
        check("toWordKept", WriteData, 32'hA3A2A1A0);
        idle(1);
        check("toOneCycle", 32'(TimeoutErr), 32'd0);
        sendWord(32'h04030201);
        check("toNextWord", WriteData, 32'h04030201);
        // Flush landing on the timeout edge suppresses the error.
        sendByte(8'h99);
        idle(15);
        Flush = 1'b1;
        idle(1);
        Flush = 1'b0;
        check("flushBeatsTo", 32'(TimeoutErr), 32'd0);
        idle(2);
        check("flushToCount", 32'(toCount), 32'd1);
`else
        sendByte(8'h55);
        sendByte(8'h66);
        idle(20);
        check("noToPulse", 32'(TimeoutErr), 32'd0);
        check("noToBusy", 32'(Busy), 32'd1);
        expQ.push_back(32'h99886655);
        sendByte(8'h88);
        sendByte(8'h99);
        check("noToWord", WriteData, 32'h99886655);
        check("noToCount", 32'(toCount), 32'd0);
`endif
        idle(2);

        // Flush after two bytes, colliding with a third byte.
        sendByte(8'hE1);
        sendByte(8'hE2);
        Data = 8'h77; DataValid = 1'b1; Flush = 1'b1;
        idle(1);
        DataValid = 1'b0; Flush = 1'b0;
        check("flushBusy", 32'(Busy), 32'd0);
        check("flushNoWdv", 32'(WriteDataValid), 32'd0);
        sendWord(32'h40302010);
        check("flushWord", WriteData, 32'h40302010);
        idle(2);

        // Asynchronous reset mid-word.
        sendByte(8'hB1);
        sendByte(8'hB2);
        sendByte(8'hB3);
        #2 ARst = 1'b1;
        #1;
        check("arstWriteData", WriteData, 32'h0);
        check("arstBusy", 32'(Busy), 32'd0);
        check("arstWdv", 32'(WriteDataValid), 32'd0);
        check("arstTimeout", 32'(TimeoutErr), 32'd0);
        @(posedge ClkIngress);
        #1 ARst = 1'b0;
        idle(1);
        sendWord(32'hC4C3C2C1);
        check("arstWord", WriteData, 32'hC4C3C2C1);

        idle(3);
        check("sbEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
